// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared opcodes, status codes and FSM encoding for the NoC ports
package noc_pkg;

    localparam int NODE_ID_W = 4;

    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_SE4K  = 8'h20;
    localparam logic [7:0] OP_BE32K = 8'h52;
    localparam logic [7:0] OP_BE64K = 8'hD8;
    localparam logic [7:0] OP_RESET = 8'h99;

    localparam logic [3:0] ST_OK    = 4'd0;
    localparam logic [3:0] ST_ERR   = 4'd1;
    localparam logic [3:0] ST_BUSY  = 4'd2;
    localparam logic [3:0] ST_BADOP = 4'd3;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_OPC  = 3'd2;
    localparam logic [2:0] S_STAT = 3'd3;
    localparam logic [2:0] S_DATA = 3'd4;
    localparam logic [2:0] S_LAST = 3'd5;

    // Only read responses carry payload; everything else is header-only.
    function automatic logic [3:0] frame_len_eff(input logic [7:0] op, input logic [3:0] len);
        return (op == OP_READ) ? len : 4'd0;
    endfunction

endpackage

// File: rtl/noc_tx_stage.sv
// rtl/noc_tx_stage.sv - single-entry output register with valid/ready hold
module noc_tx_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    output logic         free,
    output logic [W-1:0] data,
    output logic         valid,
    input  logic         ready
);

    assign free = !valid || ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load && free) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/noc_response_port.sv
// rtl/noc_response_port.sv - frames response descriptors into byte-serial NoC reply packets
module noc_response_port
    import noc_pkg::*;
#(
    parameter logic [NODE_ID_W-1:0] SELF_ID  = 4'h2,
    parameter int                   TIMEOUT  = 16,
    parameter logic [7:0]           PAD_BYTE = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rsp_valid,
    output logic       rsp_ready,
    input  logic [3:0] rsp_dest,
    input  logic [7:0] rsp_opcode,
    input  logic [3:0] rsp_status,
    input  logic [3:0] rsp_len,
    input  logic [7:0] rd_data,
    input  logic       rd_valid,
    output logic       rd_ready,
    output logic [7:0] noc_out_data,
    output logic       noc_out_valid,
    input  logic       noc_out_ready,
    output logic       rsp_done,
    output logic       rsp_err
);

    localparam int IW = $clog2(TIMEOUT + 1);

    logic [2:0]    state;
    logic [3:0]    dest_q, status_q, len_q, remain;
    logic [7:0]    opc_q;
    logic          pad;
    logic [IW-1:0] idle_cnt;
    logic          ld, free, loaded, rd_hs, last_hs;
    logic [7:0]    ld_data;

    assign rsp_ready = (state == S_IDLE);
    assign rd_ready  = (state == S_DATA) && free && !pad;
    assign rd_hs     = rd_valid && rd_ready;
    assign loaded    = ld && free;
    assign last_hs   = (state == S_LAST) && noc_out_valid && noc_out_ready;

    always_comb begin
        ld      = 1'b0;
        ld_data = 8'h00;
        case (state)
            // Header byte goes straight in on accept so byte0 shows the next cycle.
            S_IDLE: begin ld = rsp_valid;  ld_data = {rsp_dest, SELF_ID}; end
            S_HDR:  begin ld = 1'b1;       ld_data = {dest_q, SELF_ID};   end
            S_OPC:  begin ld = 1'b1;       ld_data = opc_q;               end
            S_STAT: begin ld = 1'b1;       ld_data = {status_q, len_q};   end
            S_DATA: begin
                ld      = pad ? 1'b1 : rd_hs;
                ld_data = pad ? PAD_BYTE : rd_data;
            end
            default: begin ld = 1'b0; ld_data = 8'h00; end
        endcase
    end

    noc_tx_stage #(.W(8)) u_tx_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ld),
        .load_data (ld_data),
        .free      (free),
        .data      (noc_out_data),
        .valid     (noc_out_valid),
        .ready     (noc_out_ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            dest_q   <= '0;
            status_q <= '0;
            len_q    <= '0;
            remain   <= '0;
            opc_q    <= '0;
            pad      <= 1'b0;
            idle_cnt <= '0;
            rsp_done <= 1'b0;
            rsp_err  <= 1'b0;
        end else begin
            rsp_done <= 1'b0;
            rsp_err  <= 1'b0;
            case (state)
                S_IDLE: if (rsp_valid) begin
                    dest_q   <= rsp_dest;
                    opc_q    <= rsp_opcode;
                    status_q <= rsp_status;
                    len_q    <= frame_len_eff(rsp_opcode, rsp_len);
                    remain   <= frame_len_eff(rsp_opcode, rsp_len);
                    pad      <= 1'b0;
                    idle_cnt <= '0;
                    state    <= loaded ? S_OPC : S_HDR;
                end
                S_HDR:  if (loaded) state <= S_OPC;
                S_OPC:  if (loaded) state <= S_STAT;
                S_STAT: if (loaded) state <= (len_q == 4'd0) ? S_LAST : S_DATA;
                S_DATA: begin
                    if (loaded) begin
                        remain <= remain - 4'd1;
                        if (remain == 4'd1)
                            state <= S_LAST;
                    end
                    // Idle cycles only count while the slot could have taken a byte.
                    if (rd_hs) begin
                        idle_cnt <= '0;
                    end else if (!pad && free && !rd_valid) begin
                        idle_cnt <= idle_cnt + IW'(1);
                        if (idle_cnt == IW'(TIMEOUT - 1))
                            pad <= 1'b1;
                    end
                end
                S_LAST: if (last_hs) begin
                    state    <= S_IDLE;
                    rsp_done <= 1'b1;
                    rsp_err  <= pad;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_response_port.sv
// tb/tb_noc_response_port.sv - directed self-checking bench for noc_response_port
module tb_noc_response_port;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rsp_valid = 1'b0;
    logic       rsp_ready;
    logic [3:0] rsp_dest = '0, rsp_status = '0, rsp_len = '0;
    logic [7:0] rsp_opcode = '0;
    logic [7:0] rd_data = '0;
    logic       rd_valid = 1'b0;
    logic       rd_ready;
    logic [7:0] noc_out_data;
    logic       noc_out_valid;
    logic       noc_out_ready = 1'b1;
    logic       rsp_done, rsp_err;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [7:0] mon_data[$];
    int         mon_cyc[$];
    int         done_cyc[$];
    logic       done_err[$];
    logic [7:0] src[$];
    logic       rd_pend = 1'b0;
    logic       rdr_seen = 1'b0;

    noc_response_port dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_dest      (rsp_dest),
        .rsp_opcode    (rsp_opcode),
        .rsp_status    (rsp_status),
        .rsp_len       (rsp_len),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .noc_out_data  (noc_out_data),
        .noc_out_valid (noc_out_valid),
        .noc_out_ready (noc_out_ready),
        .rsp_done      (rsp_done),
        .rsp_err       (rsp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (noc_out_valid && noc_out_ready) begin
            mon_data.push_back(noc_out_data);
            mon_cyc.push_back(cyc);
        end
        if (rsp_done) begin
            done_cyc.push_back(cyc);
            done_err.push_back(rsp_err);
        end
        if (rd_ready) rdr_seen = 1'b1;
        rd_pend = rd_valid && rd_ready;
    end

    always @(posedge clk) begin
        #1;
        if (rd_pend && src.size() > 0) void'(src.pop_front());
        rd_pend  = 1'b0;
        rd_valid = (src.size() > 0);
        rd_data  = (src.size() > 0) ? src[0] : 8'h00;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        mon_data.delete();
        mon_cyc.delete();
        done_cyc.delete();
        done_err.delete();
        rdr_seen = 1'b0;
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] exp[$], input int ecyc[$]);
        chk({tag, "_count"}, mon_data.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < mon_data.size()) begin
                chk($sformatf("%s_byte%0d", tag, i), mon_data[i], exp[i]);
                chk($sformatf("%s_cyc%0d", tag, i), mon_cyc[i], ecyc[i]);
            end
        end
    endtask

    task automatic wait_done(input int n);
        for (int k = 0; k < 200 && done_cyc.size() < n; k++) @(negedge clk);
        chk("done_wait", done_cyc.size(), n);
    endtask

    task automatic send(input logic [3:0] d, input logic [7:0] op, input logic [3:0] st,
                        input logic [3:0] ln, output int acc);
        @(posedge clk); #1;
        rsp_valid = 1'b1; rsp_dest = d; rsp_opcode = op; rsp_status = st; rsp_len = ln;
        acc = -1;
        for (int k = 0; k < 100 && acc < 0; k++) begin
            @(negedge clk);
            if (rsp_ready) acc = cyc + 1;
        end
        @(posedge clk); #1;
        rsp_valid = 1'b0;
        if (acc < 0) chk("accept_wait", 0, 1);
    endtask

    initial begin
        int a, r;
        logic [7:0] eb[$];
        int ec[$];

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_ready", rsp_ready, 1);
        chk("rst_valid", noc_out_valid, 0);
        chk("rst_data", noc_out_data, 0);
        chk("rst_rd_ready", rd_ready, 0);
        chk("rst_done", rsp_done, 0);
        chk("rst_err", rsp_err, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // write ack: payload length masked to zero
        clear_mon();
        send(4'h1, 8'h02, 4'h0, 4'h3, a);
        wait_done(1);
        repeat (3) @(negedge clk);
        eb = '{8'h12, 8'h02, 8'h00}; ec = '{a, a + 1, a + 2};
        expect_frame("wr", eb, ec);
        chk("wr_done_cyc", done_cyc[0], a + 3);
        chk("wr_err", done_err[0], 0);
        chk("wr_done_pulses", done_cyc.size(), 1);
        chk("wr_rd_ready_never", rdr_seen, 0);

        // read with streaming payload
        clear_mon();
        src = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        send(4'h1, 8'h03, 4'h0, 4'h4, a);
        wait_done(1);
        eb = '{8'h12, 8'h03, 8'h04, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
        ec = '{a, a + 1, a + 2, a + 3, a + 4, a + 5, a + 6};
        expect_frame("rd", eb, ec);
        chk("rd_done_cyc", done_cyc[0], a + 7);
        chk("rd_err", done_err[0], 0);

        // backpressure while byte1 is presented
        clear_mon();
        src = '{8'hB5};
        send(4'h1, 8'h03, 4'h0, 4'h1, a);
        @(posedge clk); #1 noc_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_data", noc_out_data, 8'h03);
            chk("bp_hold_valid", noc_out_valid, 1);
            if (i < 2) @(posedge clk);
        end
        @(posedge clk); #1 noc_out_ready = 1'b1;
        wait_done(1);
        eb = '{8'h12, 8'h03, 8'h01, 8'hB5}; ec = '{a, a + 4, a + 5, a + 6};
        expect_frame("bp", eb, ec);
        chk("bp_done_cyc", done_cyc[0], a + 7);

        // timeout padding
        clear_mon();
        send(4'h1, 8'h03, 4'h0, 4'h2, a);
        wait_done(1);
        eb = '{8'h12, 8'h03, 8'h02, 8'hFF, 8'hFF};
        ec = '{a, a + 1, a + 2, a + 19, a + 20};
        expect_frame("to", eb, ec);
        chk("to_done_cyc", done_cyc[0], a + 21);
        chk("to_err", done_err[0], 1);

        // back-to-back descriptors
        clear_mon();
        @(posedge clk); #1;
        rsp_valid = 1'b1; rsp_dest = 4'h1; rsp_opcode = 8'h02; rsp_status = 4'h0; rsp_len = 4'h0;
        a = -1;
        for (int k = 0; k < 50 && a < 0; k++) begin
            @(negedge clk);
            if (rsp_ready) a = cyc + 1;
        end
        @(posedge clk); #1;
        rsp_dest = 4'h5; rsp_opcode = 8'h20; rsp_status = 4'h3; rsp_len = 4'h7;
        r = -1;
        for (int k = 0; k < 50 && r < 0; k++) begin
            @(negedge clk);
            if (rsp_ready) r = cyc;
            else @(posedge clk);
        end
        chk("b2b_ready_cyc", r, a + 3);
        @(posedge clk); #1 rsp_valid = 1'b0;
        wait_done(2);
        eb = '{8'h12, 8'h02, 8'h00, 8'h52, 8'h20, 8'h30};
        ec = '{a, a + 1, a + 2, a + 4, a + 5, a + 6};
        expect_frame("b2b", eb, ec);
        chk("b2b_done0", done_cyc[0], a + 3);
        chk("b2b_done1", done_cyc[1], a + 7);

        // reset in the middle of the payload
        clear_mon();
        src = '{8'hC0, 8'hC1, 8'hC2};
        send(4'h1, 8'h03, 4'h0, 4'h8, a);
        repeat (5) @(posedge clk);
        #1 noc_out_ready = 1'b0;
        @(negedge clk);
        chk("mr_pre_valid", noc_out_valid, 1);
        chk("mr_pre_data", noc_out_data, 8'hC2);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_valid_async", noc_out_valid, 0);
        chk("mr_rd_ready", rd_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        noc_out_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("mr_rsp_ready", rsp_ready, 1);
        chk("mr_no_done", done_cyc.size(), 0);
        chk("mr_valid_after", noc_out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/noc_response_port.md
Name: noc_response_port

Overview:
Transmit side of the flash controller's NoC interface. The transaction FSM finishes a command and hands over a response descriptor; this block frames a reply packet and drives it byte-serially onto the 8-bit NoC bus with a valid/ready handshake. Read data comes from the data port as a byte stream. The block is the return path for commands accepted by the command port.

Parameters:
SELF_ID, 4'h2, this block's NoC node id, placed in the header source field
TIMEOUT, 16, maximum idle cycles waiting for rd_valid during payload before padding
PAD_BYTE, 8'hFF, byte substituted for missing payload after timeout

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rsp_valid  in  1  descriptor valid from transaction FSM
rsp_ready  out  1  descriptor accepted; high only in IDLE
rsp_dest  in  4  destination node id (original requester)
rsp_opcode  in  8  echoed command opcode
rsp_status  in  4  completion status code
rsp_len  in  4  payload byte count (0..15)
rd_data  in  8  payload byte from data port
rd_valid  in  1  payload byte valid
rd_ready  out  1  payload byte consumed
noc_out_data  out  8  byte to NoC
noc_out_valid  out  1  byte valid
noc_out_ready  in  1  NoC accepts byte
rsp_done  out  1  one-cycle pulse after the last byte handshake
rsp_err  out  1  one-cycle pulse alongside rsp_done when padding occurred

Behaviour:
- Reset: clk and rst_n are the only clock and reset. rst_n is asynchronous and active-low. On reset the state is IDLE and all counters are 0. noc_out_valid, noc_out_data, rd_ready, rsp_done and rsp_err are 0; rsp_ready is 1. Reset mid-frame drops the frame with no partial completion pulse.
- Frame format: byte0={rsp_dest,SELF_ID}; byte1=rsp_opcode; byte2={rsp_status,len_eff}; then len_eff payload bytes.
- len_eff = rsp_len only when rsp_opcode==OP_READ (8'h03). Otherwise len_eff is 0 and rd_ready is never asserted.
- Descriptor capture: all descriptor fields are latched on rsp_valid&&rsp_ready at cycle N. byte0 is presented with noc_out_valid=1 at cycle N+1.
- Output register: one-entry register (noc_tx_stage). Once noc_out_valid=1, noc_out_data must stay stable until noc_out_ready=1. The register can load when !noc_out_valid||noc_out_ready, which allows full throughput of 1 byte/cycle.
- States:
  - IDLE: rsp_ready=1. On accept, go to HDR.
  - HDR: load byte0, then go to OPC.
  - OPC: load byte1, then go to STAT.
  - STAT: load byte2. If len_eff==0 go to LAST, else go to DATA.
  - DATA: rd_ready = (load slot free). An rd handshake at cycle M shows the byte on the NoC at M+1. The payload counter decrements per loaded byte. When it reaches 0, go to LAST.
  - LAST: wait for the final byte handshake, then go to IDLE.
- Each state only advances when its byte loads into the output register.
- Timeout: in DATA, an idle counter increments each cycle rd_valid=0 while the slot is free, and resets on rd handshake. At TIMEOUT, rd_ready drops and all remaining bytes are loaded as PAD_BYTE. A sticky pad flag is set.
- Completion: on the final byte handshake at edge E, the state goes to IDLE and rsp_done=1 for the cycle after E. rsp_err=pad flag in that same cycle. rsp_ready=1 in that same cycle, so a new descriptor can be accepted back-to-back.
- rsp_valid outside IDLE is ignored; rsp_ready=0.
- rd_valid outside DATA is ignored.

Decomposition:
- Package noc_pkg holds:
  - OP_WRITE=8'h02, OP_READ=8'h03, OP_SE4K=8'h20, OP_BE32K=8'h52, OP_BE64K=8'hD8, OP_RESET=8'h99
  - status codes ST_OK=0, ST_ERR=1, ST_BUSY=2, ST_BADOP=3
  - FSM state encoding
  - NODE_ID_W=4
- One sub-module: noc_tx_stage. It is the single-entry output register with load/hold logic, reused by the command port for acks.

Test Plan:
- Write ack: dest=1, op=0x02, status=0, len=3, noc_out_ready=1 -> bytes 0x12,0x02,0x00 on cycles N+1..N+3; rd_ready never 1; rsp_done at N+4; rsp_err=0.
- Read: op=0x03, len=4, rd stream A0,A1,A2,A3 always valid -> 0x12,0x03,0x04,A0,A1,A2,A3 on 7 consecutive cycles; rsp_done 1 cycle after the last byte.
- Backpressure: noc_out_ready=0 for 3 cycles while byte1 presented -> noc_out_data=0x03 and valid held stable; no byte lost or duplicated; total frame unchanged.
- Timeout: op=0x03, len=2, rd_valid=0 -> header sent, 16 cycles later 0xFF,0xFF emitted; rsp_done and rsp_err pulse together.
- Back-to-back: second descriptor held valid during first frame -> rsp_ready=0 until the rsp_done cycle; second byte0 appears the cycle after acceptance.
- Reset mid-DATA (op=0x03, len=8, after 3 payload bytes): assert rst_n=0 asynchronously -> noc_out_valid=0 immediately; no rsp_done; rsp_ready=1 after release.
